// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 framing, LSB-first.
// Passes the serial line through a two-flop synchroniser, finds the start bit,
// takes each data bit at mid-bit and checks the stop bit. The received byte is
// held on a ready/acknowledge port, with framing and overrun reporting.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   RxIn         in   serial line, idle high, asynchronous to clock
//   RxAck        in   consumer acknowledge; clears RxReady
//   RxData       out  last correctly framed byte
//   RxReady      out  RxData holds an unacknowledged byte
//   FramingError out  last frame ended with a stop bit of 0
//   Overrun      out  sticky; a byte was overwritten before it was acknowledged
//   RxBusy       out  receiver is not idle
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 RxIn,
    input  logic                 RxAck,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxReady,
    output logic                 FramingError,
    output logic                 Overrun,
    output logic                 RxBusy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 ready_n, ferr_n, ovr_n, busy_n;
    logic                 sync1, rx_s;

    // Two-flop synchroniser; both flops reset to the idle (high) level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RxIn;
            rx_s  <= sync1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            RxData       <= '0;
            RxReady      <= 1'b0;
            FramingError <= 1'b0;
            Overrun      <= 1'b0;
            RxBusy       <= 1'b0;
        end else begin
            state        <= state_n;
            clk_cnt      <= clk_cnt_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            RxData       <= data_n;
            RxReady      <= ready_n;
            FramingError <= ferr_n;
            Overrun      <= ovr_n;
            RxBusy       <= busy_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = RxData;
        ready_n   = RxReady;
        ferr_n    = FramingError;
        ovr_n     = Overrun;

        // Acknowledge clears a pending byte; a load in the same cycle overrides it below.
        if (RxAck && RxReady) begin
            ready_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        ready_n = 1'b1;
                        ferr_n  = 1'b0;
                        if (RxReady && !RxAck) begin
                            ovr_n = 1'b1;
                        end
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a held-low line cannot retrigger.
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLKS_PER_BIT=16.
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       RxIn;
    logic       RxAck;
    logic [7:0] RxData;
    logic       RxReady;
    logic       FramingError;
    logic       Overrun;
    logic       RxBusy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] partial = 8'h96;

    always #5 clock = ~clock;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .RxIn        (RxIn),
        .RxAck       (RxAck),
        .RxData      (RxData),
        .RxReady     (RxReady),
        .FramingError(FramingError),
        .Overrun     (Overrun),
        .RxBusy      (RxBusy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial frame as the transmitter drives it: start, 8 bits LSB first, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        RxIn = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            RxIn = d[i];
            repeat (CPB) @(negedge clock);
        end
        RxIn = stop;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic pulse_ack();
        RxAck = 1'b1;
        @(negedge clock);
        RxAck = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        RxIn  = 1'b1;
        RxAck = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_data",  RxData, 8'h00);
        check("rst_ready", RxReady, 1'b0);
        check("rst_ferr",  FramingError, 1'b0);
        check("rst_ovr",   Overrun, 1'b0);
        check("rst_busy",  RxBusy, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Acknowledge with nothing pending is ignored
        pulse_ack();
        @(negedge clock);
        check("ack_idle_ready", RxReady, 1'b0);

        // 0xA5: RxReady rises 2 sync cycles + 153 cycles after the line falls
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(negedge clock);
                check("a5_ready_early", RxReady, 1'b0);
                @(negedge clock);
                check("a5_ready_on_time", RxReady, 1'b1);
                check("a5_data_on_time", RxData, 8'hA5);
            end
        join
        check("a5_ferr", FramingError, 1'b0);
        check("a5_ovr",  Overrun, 1'b0);
        check("a5_busy", RxBusy, 1'b0);
        pulse_ack();
        check("a5_ack_ready", RxReady, 1'b0);
        check("a5_ack_data",  RxData, 8'hA5);

        // Short low glitch is rejected at the mid start-bit check
        do_reset();
        RxIn = 1'b0;
        repeat (4) @(negedge clock);
        RxIn = 1'b1;
        check("glitch_busy", RxBusy, 1'b1);
        repeat (20) @(negedge clock);
        check("glitch_idle",  RxBusy, 1'b0);
        check("glitch_ready", RxReady, 1'b0);
        check("glitch_data",  RxData, 8'h00);

        // Bad stop bit, line held low for 40 cycles from the stop bit
        send_frame(8'h3C, 1'b0);
        check("ferr_set",   FramingError, 1'b1);
        check("ferr_ready", RxReady, 1'b0);
        check("ferr_data",  RxData, 8'h00);
        check("ferr_busy",  RxBusy, 1'b1);
        repeat (24) @(negedge clock);
        check("break_hold", RxBusy, 1'b1);
        RxIn = 1'b1;
        repeat (10) @(negedge clock);
        check("break_exit", RxBusy, 1'b0);
        send_frame(8'h3C, 1'b1);
        check("ferr_clear_data",  RxData, 8'h3C);
        check("ferr_clear_ferr",  FramingError, 1'b0);
        check("ferr_clear_ready", RxReady, 1'b1);

        // Back-to-back frames without acknowledge overrun
        do_reset();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        check("ovr_data",  RxData, 8'hC3);
        check("ovr_ready", RxReady, 1'b1);
        check("ovr_flag",  Overrun, 1'b1);

        // Same pair, acknowledge exactly on the 0xC3 load cycle
        do_reset();
        fork
            begin
                send_frame(8'h3C, 1'b1);
                send_frame(8'hC3, 1'b1);
            end
            begin
                repeat (314) @(negedge clock);
                check("ackload_pre_data", RxData, 8'h3C);
                pulse_ack();
                check("ackload_ready", RxReady, 1'b1);
                check("ackload_data",  RxData, 8'hC3);
                check("ackload_ovr",   Overrun, 1'b0);
            end
        join

        // Reset in the middle of data bit 4 of 0x96
        RxIn = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            RxIn = partial[i];
            repeat (CPB) @(negedge clock);
        end
        RxIn = partial[4];
        repeat (CPB / 2) @(negedge clock);
        check("mid_busy", RxBusy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_data",  RxData, 8'h00);
        check("mid_rst_ready", RxReady, 1'b0);
        check("mid_rst_ferr",  FramingError, 1'b0);
        check("mid_rst_ovr",   Overrun, 1'b0);
        check("mid_rst_busy",  RxBusy, 1'b0);
        RxIn = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        send_frame(8'h55, 1'b1);
        check("post_rst_data",  RxData, 8'h55);
        check("post_rst_ready", RxReady, 1'b1);
        check("post_rst_busy",  RxBusy, 1'b0);
        pulse_ack();

        // Transmitter-style byte stream with acknowledge after each
        do_reset();
        send_frame(8'h00, 1'b1);
        check("lb0_data",  RxData, 8'h00);
        check("lb0_ready", RxReady, 1'b1);
        pulse_ack();
        repeat (CPB) @(negedge clock);
        send_frame(8'hFF, 1'b1);
        check("lb1_data",  RxData, 8'hFF);
        check("lb1_ready", RxReady, 1'b1);
        pulse_ack();
        repeat (CPB) @(negedge clock);
        send_frame(8'h81, 1'b1);
        check("lb2_data",  RxData, 8'h81);
        check("lb2_ready", RxReady, 1'b1);
        check("lb_ferr",   FramingError, 1'b0);
        check("lb_ovr",    Overrun, 1'b0);
        pulse_ack();
        check("lb_final_ready", RxReady, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the downstream consumer of the transmitter's serial TxOut line. It oversamples the asynchronous serial input, detects the start bit, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit, then presents the byte on a parallel port with a ready/acknowledge handshake. It reports framing and overrun errors.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; even, >= 4
DATA_BITS, 8, data bits per frame; fixed width of RxData

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
RxIn  input  1  serial line, idle high, asynchronous to clock
RxAck  input  1  consumer acknowledge; clears RxReady
RxData  output  8  last correctly framed byte
RxReady  output  1  RxData holds an unacknowledged byte
FramingError  output  1  last frame had stop bit = 0
Overrun  output  1  sticky; a byte was overwritten before ack
RxBusy  output  1  high while state is not IDLE

Behaviour:
- Reset (async, active-high): state IDLE, bit counter 0, clock counter 0, shift register 0, synchronizer flops 1.
- Output reset values: RxData 0x00, RxReady 0, FramingError 0, Overrun 0, RxBusy 0.
- RxIn passes through a 2-flop synchronizer. All decisions use the synchronized value (rx_s). Added latency: 2 cycles.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: rx_s==0 -> START; clock counter cleared.
- START: count CLKS_PER_BIT/2 cycles, then sample rx_s.
  - rx_s==0 -> DATA; counters cleared.
  - rx_s==1 -> IDLE (false start/glitch); no output changes.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register MSB and shift right (LSB-first). After DATA_BITS samples -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - Valid stop (rx_s==1): on the next edge, RxData <= shift register, RxReady <= 1, FramingError <= 0 -> IDLE.
  - If RxReady was already 1 and RxAck is not asserted that cycle: Overrun <= 1; the new byte still overwrites RxData.
  - Invalid stop (rx_s==0): FramingError <= 1; RxData and RxReady unchanged -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. Prevents a held-low line from retriggering frames.
- Timing: RxReady rises CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the cycle rx_s first reads 0.
- Handshake:
  - RxAck==1 while RxReady==1 -> RxReady 0 next cycle.
  - RxAck while RxReady==0 is ignored.
  - RxAck in the same cycle as a new byte load: RxReady stays 1, no overrun, new data visible.
- Overrun clears only on reset. FramingError clears on the next valid frame or on reset.
- RxBusy = (state != IDLE), registered with state.
- Reset mid-frame: immediate return to IDLE with reset values. The partial frame is discarded. The next start edge is received normally.

Test Plan:
- CLKS_PER_BIT=16; drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> RxData=0xA5, RxReady=1 exactly 16/2+9*16+1=153 cycles after rx_s falls; FramingError=0, Overrun=0.
- Low glitch of 4 cycles on idle line -> START aborts at mid-bit sample, returns to IDLE; RxReady stays 0, RxData stays 0x00.
- Frame 0x3C with stop bit 0, line held low 40 cycles, then high -> FramingError=1, RxReady=0, RxData=0x00. State stays BREAK until line high, then a following 0x3C frame gives RxData=0x3C, FramingError=0.
- Frames 0x3C then 0xC3 back-to-back, no RxAck -> RxData=0xC3, RxReady=1, Overrun=1. Repeat, pulsing RxAck on the exact load cycle of 0xC3 -> Overrun=0, RxReady=1.
- Reset asserted during data bit 4 of frame 0x96 -> all outputs at reset values immediately. Next frame 0x55 -> RxData=0x55, RxReady=1.
- Loopback from the team transmitter (same CLKS_PER_BIT) sending 0x00, 0xFF, 0x81 with RxAck after each -> received bytes match in order; no FramingError or Overrun.
